// File: rtl/regdd_lane_nv.sv
// regdd_lane_nv: one frogger playfield lane. Loads a level pattern and rotates
// it with wrap-around at a selectable speed. The speed comes from a clock-enable
// divider, so there is only one clock.
// Optional collision detect output: define REGDD_LANE_COLLISION_EN.
module regdd_lane_nv #(
  parameter int                                  DATAWIDTH_BUS = 8,
  parameter int                                  NUM_LEVELS    = 4,
  parameter int                                  DATAWIDTH_NVL = 2,
  parameter logic [DATAWIDTH_BUS*NUM_LEVELS-1:0] PATTERNS      = 32'hC7553311,
  parameter int                                  TICK_FAST     = 4,
  parameter int                                  TICK_NORMAL   = 8,
  parameter int                                  TICK_SLOW     = 16
) (
  input  logic                     REGDD_LANE_CLOCK,
  input  logic                     REGDD_LANE_RESET,
  input  logic [DATAWIDTH_NVL-1:0] REGDD_LANE_NVL_IN,
  input  logic                     REGDD_LANE_CN_IN,
  input  logic [1:0]               REGDD_LANE_SPEED_IN,
  input  logic                     REGDD_LANE_DIR_IN,
  input  logic                     REGDD_LANE_PAUSE_IN,
  output logic [DATAWIDTH_BUS-1:0] REGDD_LANE_DATAPARALLEL_OUT,
  output logic                     REGDD_LANE_SHIFT_TICK_OUT,
  output logic                     REGDD_LANE_LOADED_OUT
`ifdef REGDD_LANE_COLLISION_EN
  ,
  input  logic [DATAWIDTH_BUS-1:0] REGDD_LANE_FROG_POS_IN,
  output logic                     REGDD_LANE_HIT_OUT
`endif
);

  // Divider only needs to count up to the longest period minus one.
  localparam int TICK_MAX_SN = (TICK_SLOW > TICK_NORMAL) ? TICK_SLOW : TICK_NORMAL;
  localparam int TICK_MAX    = (TICK_MAX_SN > TICK_FAST) ? TICK_MAX_SN : TICK_FAST;
  localparam int DIV_W       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  localparam logic [DIV_W-1:0] LIM_FAST   = DIV_W'(TICK_FAST - 1);
  localparam logic [DIV_W-1:0] LIM_NORMAL = DIV_W'(TICK_NORMAL - 1);
  localparam logic [DIV_W-1:0] LIM_SLOW   = DIV_W'(TICK_SLOW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic                     w_latch_level;
  logic [DATAWIDTH_NVL-1:0] r_level;
  logic [DATAWIDTH_NVL-1:0] w_level_idx;
  logic [DIV_W-1:0]         r_div;
  logic [DIV_W-1:0]         w_div_next;
  logic [DIV_W-1:0]         w_limit;
  logic [DATAWIDTH_BUS-1:0] r_lane;
  logic [DATAWIDTH_BUS-1:0] w_lane_next;
  logic [DATAWIDTH_BUS-1:0] w_rot_left;
  logic [DATAWIDTH_BUS-1:0] w_rot_right;
  logic [DATAWIDTH_BUS-1:0] w_patterns [NUM_LEVELS];
  logic                     w_run_en;
  logic                     w_tick_next;
  logic                     r_tick;
  logic                     r_loaded;

  genvar gi;

  // Unpack the level pattern table.
  generate
    for (gi = 0; gi < NUM_LEVELS; gi++) begin : g_pat
      assign w_patterns[gi] = PATTERNS[gi*DATAWIDTH_BUS +: DATAWIDTH_BUS];
    end
  endgenerate

  // One-cell rotations in both directions; the modulo handles the wrap cell.
  generate
    for (gi = 0; gi < DATAWIDTH_BUS; gi++) begin : g_rot
      assign w_rot_left[gi]  = r_lane[(gi + DATAWIDTH_BUS - 1) % DATAWIDTH_BUS];
      assign w_rot_right[gi] = r_lane[(gi + 1) % DATAWIDTH_BUS];
    end
  endgenerate

  // Out-of-range levels fall back to the last stored pattern.
  assign w_level_idx = (32'(r_level) >= NUM_LEVELS) ? DATAWIDTH_NVL'(NUM_LEVELS - 1) : r_level;

  // FSM state register.
  always_ff @(posedge REGDD_LANE_CLOCK or negedge REGDD_LANE_RESET) begin
    if (!REGDD_LANE_RESET) r_state <= S_IDLE;
    else                   r_state <= w_state_next;
  end

  // FSM next state; the level is latched on entry to LOAD.
  always_comb begin
    w_state_next  = r_state;
    w_latch_level = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_next  = S_LOAD;
        w_latch_level = 1'b1;
      end
      S_LOAD: w_state_next = S_RUN;
      S_RUN: begin
        if (REGDD_LANE_CN_IN) begin
          w_state_next  = S_LOAD;
          w_latch_level = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Terminal divider count for the selected speed (speed 0 never counts).
  always_comb begin
    w_limit = LIM_FAST;
    case (REGDD_LANE_SPEED_IN)
      2'd1:    w_limit = LIM_SLOW;
      2'd2:    w_limit = LIM_NORMAL;
      default: w_limit = LIM_FAST;
    endcase
  end

  // Divider and lane next values; a level change wins over a due tick, and
  // the >= compare lets a speed increase fire at once.
  always_comb begin
    w_run_en    = (r_state == S_RUN) && !REGDD_LANE_CN_IN &&
                  (REGDD_LANE_SPEED_IN != 2'd0) && !REGDD_LANE_PAUSE_IN;
    w_tick_next = w_run_en && (r_div >= w_limit);
    w_div_next  = r_div;
    w_lane_next = r_lane;
    if (r_state == S_LOAD) begin
      w_div_next  = '0;
      w_lane_next = w_patterns[w_level_idx];
    end else if (w_tick_next) begin
      w_div_next  = '0;
      w_lane_next = REGDD_LANE_DIR_IN ? w_rot_right : w_rot_left;
    end else if (w_run_en) begin
      w_div_next  = r_div + 1'b1;
    end
  end

  // Registered datapath and strobes.
  always_ff @(posedge REGDD_LANE_CLOCK or negedge REGDD_LANE_RESET) begin
    if (!REGDD_LANE_RESET) begin
      r_div    <= '0;
      r_lane   <= '0;
      r_tick   <= 1'b0;
      r_loaded <= 1'b0;
      r_level  <= '0;
    end else begin
      r_div    <= w_div_next;
      r_lane   <= w_lane_next;
      r_tick   <= w_tick_next;
      r_loaded <= (r_state == S_LOAD);
      if (w_latch_level) r_level <= REGDD_LANE_NVL_IN;
    end
  end

  assign REGDD_LANE_DATAPARALLEL_OUT = r_lane;
  assign REGDD_LANE_SHIFT_TICK_OUT   = r_tick;
  assign REGDD_LANE_LOADED_OUT       = r_loaded;

`ifdef REGDD_LANE_COLLISION_EN
  logic r_hit;

  // Hit is computed from the next lane value so it lines up with the display.
  always_ff @(posedge REGDD_LANE_CLOCK or negedge REGDD_LANE_RESET) begin
    if (!REGDD_LANE_RESET) r_hit <= 1'b0;
    else                   r_hit <= |(w_lane_next & REGDD_LANE_FROG_POS_IN);
  end

  assign REGDD_LANE_HIT_OUT = r_hit;
`else
  // Collision detect not built in this configuration.
`endif

endmodule

// File: tb/tb_regdd_lane_nv.sv
// Testbench for regdd_lane_nv: table-driven vectors, hand-written corner
// sequences, then randomized stimulus against a behavioural lane model.
module tb_regdd_lane_nv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] nvl;
  logic       cn;
  logic [1:0] speed;
  logic       dir;
  logic       pause;
  logic [7:0] lane;
  logic       tick;
  logic       loaded;
`ifdef REGDD_LANE_COLLISION_EN
  logic [7:0] frog;
  logic       hit;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regdd_lane_nv dut (
    .REGDD_LANE_CLOCK           (clk),
    .REGDD_LANE_RESET           (rst_n),
    .REGDD_LANE_NVL_IN          (nvl),
    .REGDD_LANE_CN_IN           (cn),
    .REGDD_LANE_SPEED_IN        (speed),
    .REGDD_LANE_DIR_IN          (dir),
    .REGDD_LANE_PAUSE_IN        (pause),
    .REGDD_LANE_DATAPARALLEL_OUT(lane),
    .REGDD_LANE_SHIFT_TICK_OUT  (tick),
    .REGDD_LANE_LOADED_OUT      (loaded)
`ifdef REGDD_LANE_COLLISION_EN
    ,
    .REGDD_LANE_FROG_POS_IN     (frog),
    .REGDD_LANE_HIT_OUT         (hit)
`endif
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] nvl;
    logic       cn;
    logic [1:0] spd;
    logic       dir;
    logic       pz;
    logic [7:0] out;
    logic       tck;
    logic       ld;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] n, input logic c, input logic [1:0] s,
                              input logic d, input logic p, input logic [7:0] o,
                              input logic t, input logic l);
    vec_t v;
    v.nvl = n; v.cn = c; v.spd = s; v.dir = d; v.pz = p;
    v.out = o; v.tck = t; v.ld = l;
    vecs.push_back(v);
  endfunction

  // ---------------- behavioural model ----------------
  int         m_st;    // 0 waiting after reset, 1 loading, 2 running
  int         m_lvl;
  int         m_cnt;   // enabled cycles elapsed since the last shift/load
  int         m_lane;
  logic       m_tick;
  logic       m_ld;

  function automatic int pattern_of(input int k);
    logic [31:0] p = 32'hC7553311;
    int kk = (k > 3) ? 3 : k;
    return int'((p >> (8 * kk)) & 32'hFF);
  endfunction

  function automatic int period_of(input logic [1:0] s);
    return (s == 2'd1) ? 16 : (s == 2'd2) ? 8 : 4;
  endfunction

  function automatic void model_reset();
    m_st = 0; m_lvl = 0; m_cnt = 0; m_lane = 0; m_tick = 1'b0; m_ld = 1'b0;
  endfunction

  function automatic void model_clk(input logic [1:0] n, input logic c, input logic [1:0] s,
                                    input logic d, input logic p);
    m_tick = 1'b0;
    m_ld   = 1'b0;
    if (m_st == 0) begin
      m_lvl = int'(n); m_st = 1;
    end else if (m_st == 1) begin
      m_lane = pattern_of(m_lvl); m_ld = 1'b1; m_cnt = 0; m_st = 2;
    end else if (c) begin
      m_lvl = int'(n); m_st = 1;
    end else if (s != 2'd0 && !p) begin
      m_cnt = m_cnt + 1;
      if (m_cnt >= period_of(s)) begin
        m_cnt  = 0;
        m_tick = 1'b1;
        if (d) m_lane = ((m_lane >> 1) | (m_lane << 7)) & 255;
        else   m_lane = ((m_lane << 1) | (m_lane >> 7)) & 255;
      end
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] n, input logic c, input logic [1:0] s,
                       input logic d, input logic p);
    nvl = n; cn = c; speed = s; dir = d; pause = p;
  endtask

  task automatic run_expect(input string name, input int cycles, input logic [7:0] o,
                            input logic t);
    for (int i = 0; i < cycles; i++) begin
      step();
      chk({name, "_out"}, 32'(lane), 32'(o));
      chk({name, "_tick"}, 32'(tick), 32'(t));
    end
  endtask

  // Watchdog: the test is a fixed number of cycles, this only guards a hang.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rticks;
    int rloads;
    logic [1:0] cs;
    logic cc, cd, cp;
    logic [1:0] cn_lvl;

    rst_n = 1'b0;
    drive(2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
`ifdef REGDD_LANE_COLLISION_EN
    frog = 8'h02;
`endif

    // Table: reset release, level 2 load, level 0 fast left, level 3 slow right.
    add(2, 0, 0, 0, 0, 8'h00, 0, 0);
    add(2, 0, 0, 0, 0, 8'h55, 0, 1);
    add(0, 0, 0, 0, 0, 8'h55, 0, 0);
    add(0, 0, 0, 0, 0, 8'h55, 0, 0);
    add(0, 1, 0, 0, 0, 8'h55, 0, 0);
    add(0, 0, 3, 0, 0, 8'h11, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 3, 0, 0, 8'h11, 0, 0);
    add(0, 0, 3, 0, 0, 8'h22, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 3, 0, 0, 8'h22, 0, 0);
    add(0, 0, 3, 0, 0, 8'h44, 1, 0);
    add(3, 1, 3, 0, 0, 8'h44, 0, 0);
    add(3, 0, 1, 1, 0, 8'hC7, 0, 1);
    for (int i = 0; i < 15; i++) add(3, 0, 1, 1, 0, 8'hC7, 0, 0);
    add(3, 0, 1, 1, 0, 8'hE3, 1, 0);

    step();
    step();
    chk("reset_out", 32'(lane), 32'h0);
    chk("reset_tick", 32'(tick), 32'h0);
    chk("reset_loaded", 32'(loaded), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].nvl, vecs[i].cn, vecs[i].spd, vecs[i].dir, vecs[i].pz);
      step();
      chk($sformatf("vec%0d_out", i), 32'(lane), 32'(vecs[i].out));
      chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].tck));
      chk($sformatf("vec%0d_loaded", i), 32'(loaded), 32'(vecs[i].ld));
      $display("vec %0d: cn=%0b spd=%0d dir=%0b pause=%0b -> out=%h tick=%0b loaded=%0b",
               i, vecs[i].cn, vecs[i].spd, vecs[i].dir, vecs[i].pz, lane, tick, loaded);
    end

    // Level change coincident with a due tick: no rotation, then reload of 8'h33.
    drive(2'd0, 1'b0, 2'd3, 1'b0, 1'b0);
    run_expect("cn_pre", 3, 8'hE3, 1'b0);
    drive(2'd1, 1'b1, 2'd3, 1'b0, 1'b0);
    step();
    chk("cn_tick_out", 32'(lane), 32'hE3);
    chk("cn_tick_tick", 32'(tick), 32'h0);
    drive(2'd0, 1'b0, 2'd3, 1'b0, 1'b0);
    step();
    chk("cn_load_out", 32'(lane), 32'h33);
    chk("cn_load_loaded", 32'(loaded), 32'h1);
    run_expect("cn_restart", 3, 8'h33, 1'b0);
    step();
    chk("cn_first_tick_out", 32'(lane), 32'h66);
    chk("cn_first_tick_tick", 32'(tick), 32'h1);
    $display("seq cn-vs-tick: lane=%h", lane);

    // Pause mid-count at normal speed; resume finishes the remaining count.
    drive(2'd0, 1'b0, 2'd2, 1'b0, 1'b0);
    run_expect("pz_pre", 3, 8'h66, 1'b0);
    drive(2'd0, 1'b0, 2'd2, 1'b0, 1'b1);
    run_expect("pz_hold", 20, 8'h66, 1'b0);
    drive(2'd0, 1'b0, 2'd2, 1'b0, 1'b0);
    run_expect("pz_resume", 4, 8'h66, 1'b0);
    step();
    chk("pz_tick_out", 32'(lane), 32'hCC);
    chk("pz_tick_tick", 32'(tick), 32'h1);
    $display("seq pause: lane=%h", lane);

    // Asynchronous reset between clock edges clears the lane at once.
    run_expect("ar_pre", 2, 8'hCC, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(lane), 32'h0);
    chk("async_rst_tick", 32'(tick), 32'h0);
    drive(2'd3, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk("rerelease_idle_out", 32'(lane), 32'h0);
    step();
    chk("rerelease_load_out", 32'(lane), 32'hC7);
    chk("rerelease_loaded", 32'(loaded), 32'h1);
    $display("seq async reset: lane=%h", lane);

    // Randomized run against the behavioural model.
    rst_n = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
    cs = 2'd3;
    cp = 1'b0;
    for (int seg = 0; seg < 20; seg++) begin
      rticks = 0;
      rloads = 0;
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 15) == 0) cs = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0)  cp = ~cp;
        cc     = ($urandom_range(0, 39) == 0);
        cd     = 1'($urandom_range(0, 1));
        cn_lvl = 2'($urandom_range(0, 3));
        drive(cn_lvl, cc, cs, cd, cp);
        step();
        model_clk(cn_lvl, cc, cs, cd, cp);
        chk("rand_out", 32'(lane), 32'(m_lane));
        chk("rand_tick", 32'(tick), 32'(m_tick));
        chk("rand_loaded", 32'(loaded), 32'(m_ld));
        if (m_tick) rticks++;
        if (m_ld)   rloads++;
      end
      $display("rand seg %0d: 40 cycles, ticks=%0d loads=%0d lane=%h", seg, rticks, rloads, lane);
    end

`ifdef REGDD_LANE_COLLISION_EN
    // Collision: frog in cell 1, lane 8'h11 rotates left into it.
    rst_n = 1'b0;
    drive(2'd0, 1'b0, 2'd3, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("hit_load_out", 32'(lane), 32'h11);
    chk("hit_load_hit", 32'(hit), 32'h0);
    run_expect("hit_pre", 3, 8'h11, 1'b0);
    step();
    chk("hit_tick_out", 32'(lane), 32'h22);
    chk("hit_tick_hit", 32'(hit), 32'h1);
    $display("seq collision: lane=%h hit=%0b", lane, hit);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
